// File: rtl/exec_operand_stage.sv
// Execute-stage operand register: RAW hazard resolution, operand select, valid/ready hold.
// Define EXEC_OPERAND_FORWARDING_EN for EX/MEM/WB forwarding; otherwise any pending writer stalls.
package exec_operand_pkg;
  typedef enum logic [3:0] {
    AluOp_ADD,
    AluOp_SUB,
    AluOp_AND,
    AluOp_OR,
    AluOp_XOR,
    AluOp_SLL,
    AluOp_SRL,
    AluOp_SRA,
    AluOp_SLT,
    AluOp_SLTU
  } AluOp;
endpackage

module exec_operand_stage
  import exec_operand_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [REG_WIDTH-1:0]  i_rs1,
  input  logic [REG_WIDTH-1:0]  i_rs2,
  input  logic [REG_WIDTH-1:0]  i_rd,
  input  logic [DATA_WIDTH-1:0] i_dataRs1,
  input  logic [DATA_WIDTH-1:0] i_dataRs2,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic                  i_selA,
  input  logic                  i_selB,
  input  AluOp                  i_aluOp,
  input  logic                  i_regWr,
  input  logic                  i_memRead,
  input  logic [DATA_WIDTH-1:0] i_exData,
  input  logic [REG_WIDTH-1:0]  i_memRd,
  input  logic [REG_WIDTH-1:0]  i_wbRd,
  input  logic                  i_memRegWr,
  input  logic                  i_wbRegWr,
  input  logic                  i_memDataValid,
  input  logic [DATA_WIDTH-1:0] i_memData,
  input  logic [DATA_WIDTH-1:0] i_wbData,
  output logic                  o_valid,
  input  logic                  i_ready,
  output AluOp                  o_aluOp,
  output logic [DATA_WIDTH-1:0] o_operandA,
  output logic [DATA_WIDTH-1:0] o_operandB,
  output logic [DATA_WIDTH-1:0] o_storeData,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [REG_WIDTH-1:0]  o_rd,
  output logic                  o_regWr,
  output logic                  o_memRead
);

  // Handshake: a word moves when valid && ready on that side; o_ready never looks at i_exData.
  logic leaving;
  logic in_xfer;
  logic use_rs1;
  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic haz1, haz2, hazard;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;

  assign leaving = o_valid && i_ready;
  assign use_rs1 = !i_selA;

  // Register x0 is hardwired, so it never matches a producer.
  assign ex_m1  = (i_rs1 != '0) && o_valid && o_regWr && (o_rd == i_rs1);
  assign ex_m2  = (i_rs2 != '0) && o_valid && o_regWr && (o_rd == i_rs2);
  assign mem_m1 = (i_rs1 != '0) && i_memRegWr && (i_memRd == i_rs1);
  assign mem_m2 = (i_rs2 != '0) && i_memRegWr && (i_memRd == i_rs2);
  assign wb_m1  = (i_rs1 != '0) && i_wbRegWr && (i_wbRd == i_rs1);
  assign wb_m2  = (i_rs2 != '0) && i_wbRegWr && (i_wbRd == i_rs2);

`ifdef EXEC_OPERAND_FORWARDING_EN
  // EX wins only if its value is final (not a load) and the producer really leaves now.
  assign haz1 = use_rs1 && (ex_m1 ? (o_memRead || !leaving) : (mem_m1 && !i_memDataValid));
  assign haz2 = ex_m2 ? (o_memRead || !leaving) : (mem_m2 && !i_memDataValid);
  assign fwd1 = ex_m1 ? i_exData : mem_m1 ? i_memData : wb_m1 ? i_wbData : i_dataRs1;
  assign fwd2 = ex_m2 ? i_exData : mem_m2 ? i_memData : wb_m2 ? i_wbData : i_dataRs2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{i_exData, i_memData, i_wbData, i_memDataValid};
  assign haz1 = use_rs1 && (ex_m1 || mem_m1 || wb_m1);
  assign haz2 = ex_m2 || mem_m2 || wb_m2;
  assign fwd1 = i_dataRs1;
  assign fwd2 = i_dataRs2;
`endif

  assign hazard  = haz1 || haz2;
  assign o_ready = (!o_valid || i_ready) && !hazard && !i_flush;
  assign in_xfer = i_valid && o_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_aluOp     <= AluOp_ADD;
      o_operandA  <= '0;
      o_operandB  <= '0;
      o_storeData <= '0;
      o_pc        <= '0;
      o_rd        <= '0;
      o_regWr     <= 1'b0;
      o_memRead   <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (in_xfer) begin
      o_valid     <= 1'b1;
      o_aluOp     <= i_aluOp;
      o_operandA  <= i_selA ? i_pc : fwd1;
      o_operandB  <= i_selB ? i_imm : fwd2;
      o_storeData <= fwd2;
      o_pc        <= i_pc;
      o_rd        <= i_rd;
      o_regWr     <= i_regWr;
      o_memRead   <= i_memRead;
    end else if (leaving) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_operand_stage.sv
// Bench for exec_operand_stage: directed scenarios plus random traffic against a queue-based reference.
module tb_exec_operand_stage;
  import exec_operand_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset, i_flush, i_valid, o_ready;
  logic [31:0] i_pc, i_dataRs1, i_dataRs2, i_imm, i_exData, i_memData, i_wbData;
  logic [4:0]  i_rs1, i_rs2, i_rd, i_memRd, i_wbRd;
  logic        i_selA, i_selB, i_regWr, i_memRead;
  AluOp        i_aluOp, o_aluOp;
  logic        i_memRegWr, i_wbRegWr, i_memDataValid;
  logic        o_valid, i_ready;
  logic [31:0] o_operandA, o_operandB, o_storeData, o_pc;
  logic [4:0]  o_rd;
  logic        o_regWr, o_memRead;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        regwr;
    logic        memrd;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] sd;
  } entry_t;
  localparam int EW = $bits(entry_t);

  logic [EW-1:0] exp_q[$];
  int nchecks = 0;
  int nerrors = 0;

  always #5 i_clock = ~i_clock;

  exec_operand_stage #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_dataRs1(i_dataRs1), .i_dataRs2(i_dataRs2), .i_imm(i_imm), .i_selA(i_selA),
    .i_selB(i_selB), .i_aluOp(i_aluOp), .i_regWr(i_regWr), .i_memRead(i_memRead),
    .i_exData(i_exData), .i_memRd(i_memRd), .i_wbRd(i_wbRd), .i_memRegWr(i_memRegWr),
    .i_wbRegWr(i_wbRegWr), .i_memDataValid(i_memDataValid), .i_memData(i_memData),
    .i_wbData(i_wbData), .o_valid(o_valid), .i_ready(i_ready), .o_aluOp(o_aluOp),
    .o_operandA(o_operandA), .o_operandB(o_operandB), .o_storeData(o_storeData),
    .o_pc(o_pc), .o_rd(o_rd), .o_regWr(o_regWr), .o_memRead(o_memRead)
  );

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: walk the producers youngest-first; first one writing rs decides.
  function automatic void resolve(input logic used, input logic [4:0] rs, input logic [31:0] rf,
                                  output logic stall, output logic [31:0] val);
    entry_t      h;
    logic [4:0]  rds[3];
    logic        wr[3];
    logic [31:0] dat[3];
    logic        blocked[3];
    h = '0;
    if (exp_q.size() != 0) h = entry_t'(exp_q[0]);
    rds     = '{h.rd, i_memRd, i_wbRd};
    wr      = '{(exp_q.size() != 0) && h.regwr, i_memRegWr, i_wbRegWr};
    dat     = '{i_exData, i_memData, i_wbData};
    blocked = '{h.memrd || !i_ready, !i_memDataValid, 1'b0};
    stall = 1'b0;
    val   = rf;
    if (rs == 5'd0) return;
    for (int i = 0; i < 3; i++) begin
      if (wr[i] && rds[i] == rs) begin
`ifdef EXEC_OPERAND_FORWARDING_EN
        stall = used && blocked[i];
        val   = dat[i];
`else
        stall = used;
`endif
        return;
      end
    end
  endfunction

  // One cycle: called just after the negedge once inputs are set; returns to caller at posedge.
  task automatic step(output logic acc, output logic rdy);
    logic s1, s2, exp_rdy;
    logic [31:0] v1, v2;
    entry_t e;
    #1;
    acc = 1'b0;
    rdy = o_ready;
    if (!i_reset) begin
      chk("o_valid", o_valid, exp_q.size() != 0);
      resolve(!i_selA, i_rs1, i_dataRs1, s1, v1);
      resolve(1'b1, i_rs2, i_dataRs2, s2, v2);
      exp_rdy = (exp_q.size() == 0 || i_ready) && !s1 && !s2 && !i_flush;
      chk("o_ready", o_ready, exp_rdy);
      if (i_valid && exp_rdy) begin
        e.op    = i_aluOp;
        e.pc    = i_pc;
        e.rd    = i_rd;
        e.regwr = i_regWr;
        e.memrd = i_memRead;
        e.opa   = i_selA ? i_pc : v1;
        e.opb   = i_selB ? i_imm : v2;
        e.sd    = v2;
        exp_q.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge i_clock);
    if (i_reset || i_flush) exp_q.delete();
  endtask

  // Monitor: while an entry is held it must match the queue head; it retires on out-transfer.
  initial begin
    forever begin
      @(negedge i_clock);
      #2;
      if (!i_reset && o_valid) begin
        if (exp_q.size() == 0) begin
          nchecks++;
          nerrors++;
          $display("FAIL held_entry: got o_valid=1 expected no held entry");
        end else begin
          chk("held_entry", {o_aluOp, o_pc, o_rd, o_regWr, o_memRead, o_operandA, o_operandB,
              o_storeData}, exp_q[0]);
          if (i_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_dec(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                         input logic [31:0] d1, d2, imm, input logic sa, sb, input AluOp op,
                         input logic rw, mr);
    i_valid = v; i_pc = pc; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_dataRs1 = d1; i_dataRs2 = d2; i_imm = imm; i_selA = sa; i_selB = sb;
    i_aluOp = op; i_regWr = rw; i_memRead = mr;
  endtask

  task automatic set_env(input logic [4:0] mrd, input logic mwr, input logic mdv,
                         input logic [31:0] md, input logic [4:0] wrd, input logic wwr,
                         input logic [31:0] wd, input logic [31:0] ex);
    i_memRd = mrd; i_memRegWr = mwr; i_memDataValid = mdv; i_memData = md;
    i_wbRd = wrd; i_wbRegWr = wwr; i_wbData = wd; i_exData = ex;
  endtask

  task automatic idle(input int n);
    logic a, r;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clock);
      i_reset = 0; i_flush = 0; i_ready = 1;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, AluOp_ADD, 0, 0);
      set_env(0, 0, 1, 0, 0, 0, 0, 0);
      step(a, r);
    end
  endtask

  // Producer x5 then consumer ADD x6,x5,x1; MEM/WB follow the producer down the pipe.
  task automatic dep_pair(input string name, input logic is_load, input int npend,
                          input logic [31:0] val, input int exp_stalls);
    logic a, r;
    int   stalls;
    bit   done;
    stalls = 0;
    done = 0;
    @(negedge i_clock);
    i_ready = 1; i_flush = 0;
    set_env(0, 0, 1, 0, 0, 0, 0, 0);
    set_dec(1, 32'h100, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 0, 0, 0, AluOp_ADD, 1, is_load);
    step(a, r);
    for (int k = 1; k < 16 && !done; k++) begin
      @(negedge i_clock);
      set_dec(1, 32'h104, 5'd5, 5'd1, 5'd6, (k >= 4 + npend) ? val : 32'hDEAD0000, 32'd3, 0,
              0, 0, AluOp_ADD, 1, 0);
      set_env(0, 0, 1, 32'hBAD0BAD0, 0, 0, 32'hBAD1BAD1, (k == 1 && !is_load) ? val : 32'hBAD2);
      if (k >= 2 && k <= 2 + npend) begin
        i_memRd = 5'd5; i_memRegWr = 1;
        i_memDataValid = (k == 2 + npend);
        if (k == 2 + npend) i_memData = val;
      end
      if (k == 3 + npend) begin
        i_wbRd = 5'd5; i_wbRegWr = 1; i_wbData = val;
      end
      step(a, r);
      if (r) done = 1;
      else stalls++;
    end
    if (!done) begin
      nchecks++;
      nerrors++;
      $display("FAIL %s_timeout: got no capture expected capture within 15 cycles", name);
    end
    chk({name, "_stalls"}, stalls, exp_stalls);
    @(negedge i_clock);
    chk({name, "_opA"}, o_operandA, val);
    chk({name, "_opB"}, o_operandB, 32'd3);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, AluOp_ADD, 0, 0);
    set_env(0, 0, 1, 0, 0, 0, 0, 0);
    step(a, r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1);
  end

  initial begin
    logic a, r;
    logic [31:0] snap[4];

    // Reset held two cycles with a valid instruction present.
    i_reset = 1; i_flush = 0; i_ready = 1;
    set_dec(1, 32'h4000, 5'd3, 5'd4, 5'd7, 32'h1234, 32'h5678, 32'h9, 0, 0, AluOp_SUB, 1, 0);
    set_env(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_aluop", o_aluOp, AluOp_ADD);
    chk("rst_opA", o_operandA, 32'd0);
    chk("rst_opB", o_operandB, 32'd0);
    i_reset = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, AluOp_ADD, 0, 0);
    step(a, r);
    chk("rst_ready", r, 1'b1);

    // Dependant pairs: ALU producer then load producer with two pending MEM cycles.
`ifdef EXEC_OPERAND_FORWARDING_EN
    dep_pair("dep_alu", 1'b0, 0, 32'h10, 0);
    idle(1);
    dep_pair("load_use", 1'b1, 2, 32'hABCD, 3);
`else
    dep_pair("dep_alu", 1'b0, 0, 32'h10, 3);
    idle(1);
    dep_pair("load_use", 1'b1, 2, 32'hABCD, 5);
`endif
    idle(1);

    // Priority MEM > WB > regfile, then x0 ignoring a MEM write to x0.
`ifdef EXEC_OPERAND_FORWARDING_EN
    @(negedge i_clock);
    set_dec(1, 32'h300, 5'd9, 5'd0, 5'd10, 32'h3, 32'h55, 0, 0, 0, AluOp_OR, 1, 0);
    set_env(5'd9, 1, 1, 32'h1, 5'd9, 1, 32'h2, 32'h0);
    step(a, r);
    @(negedge i_clock);
    chk("prio_opA", o_operandA, 32'h1);
`else
    @(negedge i_clock);
`endif
    set_dec(1, 32'h304, 5'd0, 5'd0, 5'd11, 32'h77, 32'h66, 0, 0, 0, AluOp_XOR, 1, 0);
    set_env(5'd0, 1, 1, 32'h1, 5'd0, 1, 32'h2, 32'h0);
    i_ready = 1;
    step(a, r);
    @(negedge i_clock);
    chk("x0_opA", o_operandA, 32'h77);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, AluOp_ADD, 0, 0);
    set_env(0, 0, 1, 0, 0, 0, 0, 0);
    step(a, r);

    // Back-pressure: held entry stays put for four cycles; then flush drops both.
    @(negedge i_clock);
    set_dec(1, 32'h200, 5'd1, 5'd2, 5'd12, 32'hA, 32'hB, 32'hC, 1, 1, AluOp_SLT, 1, 0);
    step(a, r);
    @(negedge i_clock);
    snap = '{o_pc, o_operandA, o_operandB, o_storeData};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge i_clock);
      i_ready = 0;
      set_dec(1, 32'h204, 5'd3, 5'd4, 5'd13, 32'h1, 32'h2, 32'h3, 0, 0, AluOp_AND, 1, 0);
      step(a, r);
      chk("bp_ready", r, 1'b0);
      chk("bp_stable", {o_pc, o_operandA, o_operandB, o_storeData},
          {snap[0], snap[1], snap[2], snap[3]});
    end
    @(negedge i_clock);
    i_flush = 1;
    step(a, r);
    @(negedge i_clock);
    chk("flush_valid", o_valid, 1'b0);
    i_flush = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, AluOp_ADD, 0, 0);
    i_ready = 1;
    step(a, r);

    // Random traffic with small register indices so producers collide often.
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clock);
      i_reset = ($urandom_range(0, 199) == 0);
      i_flush = ($urandom_range(0, 19) == 0);
      i_ready = i_flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      set_dec($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AluOp'(4'($urandom_range(0, 9))),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      set_env(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
              $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      step(a, r);
    end
    i_reset = 0;
    idle(3);
    chk("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/exec_operand_stage.md
# exec_operand_stage

Execute-stage pipeline register that sits directly upstream of the ALU: it accepts a decoded instruction from decode, resolves RAW hazards by forwarding (EX, MEM, WB) or stalling, selects operands (rs1/PC, rs2/immediate) and holds a stable `AluOp` plus operands A/B for the ALU. It uses a valid/ready handshake on both sides so that decode stalls and downstream back-pressure propagate cycle-exactly.

## Interface
- DATA_WIDTH, 32, width of Data / PC / immediate
- REG_WIDTH, 5, register-index width
- i_clock  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  drop held and incoming instruction (branch redirect)
- i_valid  in  1  decode has an instruction
- o_ready  out  1  stage accepts this cycle
- i_pc  in  DATA_WIDTH  instruction PC
- i_rs1, i_rs2, i_rd  in  REG_WIDTH  register indices
- i_dataRs1, i_dataRs2  in  DATA_WIDTH  register-file read data
- i_imm  in  DATA_WIDTH  sign-extended immediate
- i_selA  in  1  0: rs1, 1: PC
- i_selB  in  1  0: rs2, 1: immediate
- i_aluOp  in  AluOp  operation
- i_regWr  in  1  instruction writes rd
- i_memRead  in  1  instruction is a load
- i_exData  in  DATA_WIDTH  ALU result of the held instruction (combinational return)
- i_memRd, i_wbRd  in  REG_WIDTH  destination in MEM / WB
- i_memRegWr, i_wbRegWr  in  1  MEM / WB writes its rd
- i_memDataValid  in  1  i_memData final (0 while MEM load pending)
- i_memData, i_wbData  in  DATA_WIDTH  MEM / WB results
- o_valid  out  1  held instruction valid
- i_ready  in  1  downstream accepts
- o_aluOp  out  AluOp  to ALU i_op
- o_operandA, o_operandB  out  DATA_WIDTH  to ALU operands
- o_storeData  out  DATA_WIDTH  forwarded rs2 value (for stores)
- o_pc  out  DATA_WIDTH, o_rd  out  REG_WIDTH, o_regWr  out  1, o_memRead  out  1

## Operation
- Out-transfer: o_valid && i_ready. In-transfer: i_valid && o_ready.
- Source rsN needs data only if used: rs1 when i_selA=0; rs2 always (store data).
- Index 0 never matches, never stalls; reads as i_dataRsN (zero from regfile).
- Forward priority per source: EX (held entry, o_valid && o_regWr && o_rd match, leaving this cycle) > MEM (i_memRegWr && i_memRd match) > WB > i_dataRsN.
- Hazard (stall): EX match where held entry is o_memRead=1; or EX match where held entry is not leaving this cycle; or MEM match with i_memDataValid=0.
- o_ready = (!o_valid || i_ready) && !hazard && !i_flush.
- On in-transfer: capture PC, rd, regWr, memRead, aluOp; operandA = selA ? pc : fwdRs1; operandB = selB ? imm : fwdRs2; storeData = fwdRs2; o_valid←1.
- On out-transfer with no in-transfer: o_valid←0. No transfer: all registers hold.
- i_flush: o_valid←0, incoming dropped; overrides in/out transfer.
- i_reset: overrides all; o_valid=0, o_pc/operands/storeData/o_rd=0, o_regWr=0, o_memRead=0, o_aluOp=AluOp_ADD.
- Outputs other than o_valid are don't-care while o_valid=0 but must not toggle unless an in-transfer occurs.

## Timing
- Latency 1 cycle: accepted at edge N, presented to ALU from N until out-transfer.
- Throughput 1/cycle with no hazards and i_ready=1.
- o_ready combinational from i_ready, i_flush and forwarding compares; no dependency on i_exData value.
- Load-use: exactly 1 bubble (held load leaves, o_valid=0 next cycle, dependant captured once MEM data valid); more while i_memDataValid=0.
- Reset mid-transfer: capture suppressed, state as above on next cycle.

## Configuration
- EXEC_OPERAND_FORWARDING_EN defined: forwarding as above.
- Undefined: no forwarding mux; any source match against held entry (regWr), MEM or WB is a hazard; operands taken only from i_dataRsN/PC/imm.

## Test plan
- Reset: i_reset=1 two cycles with i_valid=1 -> o_valid=0, o_aluOp=AluOp_ADD, o_operandA/B=0, o_ready=1 after release.
- Back-to-back dependant: ADD x5 (exData=0x10) then ADD x6,x5,x1 (x1=3) -> second captured operandA=0x10, no stall, operandB=3.
- Load-use: LW x7 then ADD x8,x7,x0 with i_memDataValid=0 two cycles, then memData=0xABCD valid -> o_ready=0 three cycles, operandA=0xABCD on capture.
- Priority: MEM rd=9 data 0x1, WB rd=9 data 0x2, i_dataRs1=0x3 -> operandA=0x1; rs1=x0 with MEM rd=0 -> i_dataRs1.
- Back-pressure/flush: i_ready=0 four cycles -> outputs stable, o_ready=0; i_flush=1 with i_valid=1 -> o_valid=0 next cycle, nothing captured.
- Macro off: same dependant pair as test 2 -> 1+ stall cycles until WB clears, operandA from i_dataRs1.
